mux_4x1_arbiter: RTL and testbench

MUX_4X1_ARBITER -- requirements
Module: mux_4x1_arbiter

---
 rtl/mux_4x1_arbiter.sv | 79 +++++++
 tb/tb_mux_4x1_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/mux_4x1_arbiter.sv
// mux_4x1_arbiter: round-robin 4-requester arbiter driving a gated 4:1 mux select; optional forced release under `ARB_TIMEOUT_EN.
module mux_4x1_arbiter #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic       sel_a,
  output logic       sel_b,
  output logic       mux_off,
  output logic       timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, idx, win, cand, sel_n;
  logic [3:0] gnt_n;
  logic       mux_off_n, rel, to_hit;
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("HOLD_MAX out of range 1..255");
  end
  assign idx = {sel_a, sel_b};
  // Descending scan so the requester closest to ptr wins.
  always_comb begin
    win = ptr;
    cand = ptr;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) win = cand;
    end
  end
`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt;
  assign to_hit = (state == GRANT) && (cnt == 8'(HOLD_MAX - 1));
  always_ff @(posedge clk) begin
    cnt     <= (rst || state == IDLE) ? 8'd0 : cnt + 8'd1;
    timeout <= rst ? 1'b0 : to_hit & ~done & req[idx];
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif
  assign rel = done | ~req[idx] | to_hit;
  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    sel_n     = idx;
    mux_off_n = mux_off;
    ptr_n     = ptr;
    if (state == IDLE) begin
      state_n   = |req ? GRANT : IDLE;
      gnt_n     = |req ? 4'b0001 << win : 4'b0000;
      sel_n     = |req ? win : idx;
      mux_off_n = ~|req;
    end else if (rel) begin
      state_n   = IDLE;
      gnt_n     = 4'b0000;
      mux_off_n = 1'b1;
      ptr_n     = idx + 2'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= 4'b0000;
      sel_a   <= 1'b0;
      sel_b   <= 1'b0;
      mux_off <= 1'b1;
      ptr     <= 2'd0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      {sel_a, sel_b} <= sel_n;
      mux_off <= mux_off_n;
      ptr     <= ptr_n;
    end
  end
endmodule

// File: tb/tb_mux_4x1_arbiter.sv
// tb_mux_4x1_arbiter: vector table, corner sequences and randomized run against a behavioural model.
module tb_mux_4x1_arbiter;
  localparam int HM = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, done = 1'b0, sel_a, sel_b, mux_off, timeout;
  logic [3:0] req = 4'b0000, gnt;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  mux_4x1_arbiter #(.HOLD_MAX(HM)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done), .gnt(gnt),
    .sel_a(sel_a), .sel_b(sel_b), .mux_off(mux_off), .timeout(timeout)
  );
  typedef struct {
    logic       r;
    logic [3:0] q;
    logic       d;
    logic [3:0] eg;
    logic [1:0] es;
    logic       eo;
  } vec_t;
  vec_t tbl[22];
  task automatic step(input logic r, input logic [3:0] q, input logic d);
    rst = r; req = q; done = d;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] es,
                       input logic eo, input logic et);
    vectors++;
    if ({gnt, sel_a, sel_b, mux_off, timeout} !== {eg, es, eo, et}) begin
      miscompares++;
      $display("FAIL %s: got gnt=%b sel=%b%b mux_off=%b timeout=%b, want gnt=%b sel=%b mux_off=%b timeout=%b",
               name, gnt, sel_a, sel_b, mux_off, timeout, eg, es, eo, et);
    end
  endtask
  // Model state: owner (-1 = nobody), rotating pointer, cycles spent in grant.
  int m_own, m_ptr, m_hold, m_sel;
  bit m_to;
  task automatic model(input logic r, input logic [3:0] q, input logic d);
    bit natural;
    m_to = 0;
    if (r) begin
      m_own = -1; m_ptr = 0; m_hold = 0; m_sel = 0;
    end else if (m_own < 0) begin
      for (int k = 0; k < 4; k++)
        if (m_own < 0 && q[(m_ptr + k) % 4]) begin
          m_own = (m_ptr + k) % 4; m_sel = m_own; m_hold = 0;
        end
    end else begin
      m_hold++;
      natural = d || !q[m_own];
      if (natural || (TO_EN && m_hold >= HM)) begin
        m_to = TO_EN && !natural;
        m_ptr = (m_own + 1) % 4;
        m_own = -1;
      end
    end
  endtask
  initial begin
    tbl = '{
      '{1, 4'b0000, 0, 4'b0000, 2'd0, 1}, '{0, 4'b0001, 0, 4'b0001, 2'd0, 0},
      '{0, 4'b0001, 1, 4'b0000, 2'd0, 1}, '{0, 4'b1111, 0, 4'b0010, 2'd1, 0},
      '{0, 4'b1111, 1, 4'b0000, 2'd1, 1}, '{0, 4'b1111, 0, 4'b0100, 2'd2, 0},
      '{0, 4'b1111, 1, 4'b0000, 2'd2, 1}, '{0, 4'b1111, 0, 4'b1000, 2'd3, 0},
      '{0, 4'b1111, 1, 4'b0000, 2'd3, 1}, '{0, 4'b1111, 0, 4'b0001, 2'd0, 0},
      '{0, 4'b1111, 1, 4'b0000, 2'd0, 1}, '{0, 4'b0100, 0, 4'b0100, 2'd2, 0},
      '{0, 4'b0110, 0, 4'b0100, 2'd2, 0}, '{0, 4'b0110, 1, 4'b0000, 2'd2, 1},
      '{0, 4'b0110, 0, 4'b0010, 2'd1, 0}, '{0, 4'b0000, 1, 4'b0000, 2'd1, 1},
      '{0, 4'b0000, 0, 4'b0000, 2'd1, 1}, '{0, 4'b1000, 0, 4'b1000, 2'd3, 0},
      '{0, 4'b1111, 0, 4'b1000, 2'd3, 0}, '{1, 4'b1111, 0, 4'b0000, 2'd0, 1},
      '{0, 4'b1111, 0, 4'b0001, 2'd0, 0}, '{0, 4'b0000, 0, 4'b0000, 2'd0, 1}
    };
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].r, tbl[i].q, tbl[i].d);
      check($sformatf("tbl[%0d]", i), tbl[i].eg, tbl[i].es, tbl[i].eo, 1'b0);
    end
    // Requester 2 holds req with done low: forced release only with the timeout feature.
    step(0, 4'b0100, 0);
    check("hold_first", 4'b0100, 2'd2, 0, 0);
    if (TO_EN) begin
      for (int i = 0; i < HM - 1; i++) begin
        step(0, 4'b0100, 0);
        check("hold_keep", 4'b0100, 2'd2, 0, 0);
      end
      step(0, 4'b0100, 0);
      check("timeout_release", 4'b0000, 2'd2, 1, 1);
      step(0, 4'b0100, 0);
      check("timeout_regrant", 4'b0100, 2'd2, 0, 0);
    end else begin
      for (int i = 0; i < 300; i++) begin
        step(0, 4'b0100, 0);
        check("no_timeout_hold", 4'b0100, 2'd2, 0, 0);
      end
    end
    step(1, 4'b0000, 0);
    model(1, 4'b0000, 0);
    check("rand_reset", 4'b0000, 2'd0, 1, 0);
    for (int i = 0; i < 600; i++) begin
      logic r, d;
      logic [3:0] q;
      r = ($urandom_range(0, 39) == 0);
      d = ($urandom_range(0, 3) == 0);
      q = 4'($urandom);
      step(r, q, d);
      model(r, q, d);
      check($sformatf("rand[%0d]", i), m_own < 0 ? 4'b0000 : 4'b0001 << m_own,
            2'(m_sel), m_own < 0, m_to);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
